noc_input_buffer: RTL and testbench
===================================

Name: noc_input_buffer

Overview:
- Receive-side port buffer of a NoC router; sits directly downstream of a neighbouring router's send link (enable/data/credit).
- Captures incoming 16-bit flits into a DEPTH-entry FIFO and presents them to the local switch stage via valid/ready.
- Returns one credit pulse upstream per flit dequeued, closing the credit-based flow-control loop.

Parameters:
- DEPTH, 4, FIFO entries; also the credit count the upstream sender is initialised with; power of two, >= 2
- WIDTH, 16, flit width in bits; must equal the link data width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- in_enable  input  1  upstream flit valid this cycle
- in_data  input  WIDTH  upstream flit
- in_credit  output  1  one-cycle pulse returning one credit upstream
- out_valid  output  1  head flit available to switch stage
- out_data  output  WIDTH  head flit
- out_ready  input  1  switch stage accepts head flit this cycle
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- err_overflow  output  1  sticky; flit arrived with no space

Behaviour:
- Reset (rst=0, async assert, sync release): wr_ptr=rd_ptr=0, count=0, out_valid=0, out_data=0, in_credit=0, err_overflow=0. Storage contents need not be cleared.
- Push: in_enable=1 and (count<DEPTH or pop this cycle) -> in_data written at wr_ptr, wr_ptr increments.
- Pop: out_valid && out_ready -> rd_ptr increments.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is tracked by the separate count register, never derived from the pointers.
- count next value:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop, including at count=0 and count=DEPTH
- out_valid = (count!=0), combinational from registers. out_data = mem[rd_ptr], registered-array read with no combinational path from in_data.
- Latency: a flit pushed in cycle N is visible on out_data/out_valid in cycle N+1. There is no same-cycle bypass, even when empty.
- Credit return:
  - in_credit is registered: it is 1 in cycle N+1 iff a pop occurred in cycle N.
  - Exactly one pulse per popped flit; back-to-back pops give back-to-back pulses.
  - No credit is issued for dropped flits.
- Full with a simultaneous pop: an incoming flit is accepted, count stays DEPTH, and a credit is issued for the pop.
- Full with no pop and in_enable=1: the flit is dropped, state is unchanged, and err_overflow is set to 1. It stays set until reset. This indicates an upstream protocol violation.
- Empty with out_ready=1: no pop and no credit, because out_valid=0.
- out_data while out_valid=0: don't-care, but must not be X after the first write.
- Reset mid-operation: all in-flight flits are discarded, and any pending in_credit pulse is squashed (in_credit reads 0 during and after reset). The upstream sender is reset concurrently and re-initialises to DEPTH credits.
- Assertions (bench-side):
  - in_enable while count==DEPTH and !out_ready implies err_overflow next cycle
  - count<=DEPTH always
  - cumulative credits issued == cumulative pops

Decomposition:
- Shared package noc_pkg:
  - FLIT_W=16
  - DEFAULT_BUF_DEPTH=4
  - typedef flit_t (logic [FLIT_W-1:0])
- These are reused by the send-side credit counter and the router top.
- One natural sub-module: noc_fifo_mem, a DEPTH x WIDTH register array with one write port and one async read port, addressed by the pointers.
- Pointer, count, credit and error logic live in noc_input_buffer.

Test Plan:
- Single flit: reset, in_enable=1 with in_data=16'hA5A5 for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=16'hA5A5, count=1; then out_ready=1 for 1 cycle -> count=0 and in_credit=1 exactly one cycle later.
- Fill to full: push 16'h0001..16'h0004 with out_ready=0 -> count=4, no in_credit. Drain with out_ready=1 -> out_data 1,2,3,4 in order, 4 consecutive credit pulses, count returns to 0.
- Wrap-around: push and pop continuously for 10 flits 16'h0010..16'h0019 with out_ready=1 -> output order preserved across the pointer wrap, count toggles between 0 and 1, 10 credits total.
- Full with simultaneous push and pop: at count=4 assert in_enable (data 16'hBEEF) and out_ready together -> count stays 4, err_overflow=0, 16'hBEEF emerges 4th after the popped flit, 1 credit.
- Overflow: at count=4 with out_ready=0 assert in_enable (16'hDEAD) -> count stays 4, err_overflow=1 and sticky, 16'hDEAD never appears on out_data.
- Reset mid-stream: at count=3 pop once and assert rst=0 in the cycle the credit would fire -> in_credit=0, count=0, out_valid=0, err_overflow=0 immediately (async). After release, a new push behaves as in the single-flit test.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC link definitions used by the receive buffer, the send-side credit
// counter and the router top.
package noc_pkg;

  localparam int FLIT_W            = 16;
  localparam int DEFAULT_BUF_DEPTH = 4;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage : noc_pkg

// File: rtl/noc_input_buffer_if.sv
// Link between an upstream sender (enable/data/credit) and the local switch stage (valid/ready).
// The master side is the environment; the slave side is the input buffer.
interface noc_input_buffer_if
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W
);

  logic             in_enable;
  logic [WIDTH-1:0] in_data;
  logic             in_credit;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_enable, in_data, out_ready,
    input  in_credit, out_valid, out_data
  );

  modport slave (
    input  in_enable, in_data, out_ready,
    output in_credit, out_valid, out_data
  );

endinterface : noc_input_buffer_if

// File: rtl/noc_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner guarantees reads only of written slots.
module noc_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : noc_fifo_mem

// File: rtl/noc_input_buffer.sv
// Receive-side router port buffer: captures upstream flits into a FIFO, presents them
// to the switch via valid/ready and returns one credit per dequeued flit.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH = DEFAULT_BUF_DEPTH,
  parameter int WIDTH = FLIT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  noc_input_buffer_if.slave          link,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_overflow
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             credit_q, credit_d;
  logic             err_q,    err_d;

  logic             full;
  logic             out_valid;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] rd_data;

  assign out_valid = (count_q != '0);

  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = out_valid && link.out_ready;
    // A pop in the same cycle frees the head slot, so a full buffer can still accept.
    push     = link.in_enable && (!full || pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = pop;
    err_d    = err_q | (link.in_enable && !push);

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  noc_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (link.in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Masking keeps out_data at zero out of reset while storage is still unwritten.
  assign link.out_valid = out_valid;
  assign link.out_data  = out_valid ? rd_data : '0;
  assign link.in_credit = credit_q;
  assign count          = count_q;
  assign err_overflow   = err_q;

endmodule : noc_input_buffer

// File: tb/tb_noc_input_buffer.sv
// Self-checking bench for noc_input_buffer: directed scenarios plus a randomized run
// compared against a queue-based model of the buffer and its credit return.
module tb_noc_input_buffer;
  import noc_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [2:0] count;
  logic       err_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  flit_t mq[$];
  bit    m_err;
  bit    m_credit;
  int    pops_model;
  int    credits_seen;

  noc_input_buffer_if #(.WIDTH(FLIT_W)) link ();

  noc_input_buffer #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .link         (link),
    .count        (count),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, advance the model by the buffer rules, sample 1ns after the edge.
  task automatic cycle(input logic en, input flit_t d, input logic rdy);
    bit pop;
    bit full;
    link.in_enable = en;
    link.in_data   = d;
    link.out_ready = rdy;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (pop) begin
      void'(mq.pop_front());
      pops_model++;
    end
    if (en && (!full || pop)) mq.push_back(d);
    else if (en) m_err = 1'b1;
    m_credit = pop;
    @(posedge clk);
    #1;
    if (link.in_credit === 1'b1) credits_seen++;
  endtask

  task automatic model_clear();
    mq.delete();
    m_err        = 1'b0;
    m_credit     = 1'b0;
    pops_model   = 0;
    credits_seen = 0;
  endtask

  task automatic test_reset();
    link.in_enable = 1'b0;
    link.in_data   = '0;
    link.out_ready = 1'b0;
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_checks++; if (link.out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", link.out_valid); else n_pass++;
    n_checks++; if (link.out_data !== 16'h0) $display("FAIL reset_data got %h exp 0000", link.out_data); else n_pass++;
    n_checks++; if (link.in_credit !== 1'b0) $display("FAIL reset_credit got %b exp 0", link.in_credit); else n_pass++;
    n_checks++; if (err_overflow !== 1'b0) $display("FAIL reset_err got %b exp 0", err_overflow); else n_pass++;
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_single(input string tag);
    cycle(1'b1, 16'hA5A5, 1'b0);
    n_checks++; if (link.out_valid !== 1'b1) $display("FAIL %s_valid got %b exp 1", tag, link.out_valid); else n_pass++;
    n_checks++; if (link.out_data !== 16'hA5A5) $display("FAIL %s_data got %h exp a5a5", tag, link.out_data); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL %s_count got %0d exp 1", tag, count); else n_pass++;
    n_checks++; if (link.in_credit !== 1'b0) $display("FAIL %s_early_credit got %b exp 0", tag, link.in_credit); else n_pass++;
    cycle(1'b0, '0, 1'b1);
    n_checks++; if (count !== 3'd0) $display("FAIL %s_count_after_pop got %0d exp 0", tag, count); else n_pass++;
    n_checks++; if (link.in_credit !== 1'b1) $display("FAIL %s_credit got %b exp 1", tag, link.in_credit); else n_pass++;
    cycle(1'b0, '0, 1'b1);
    n_checks++; if (link.in_credit !== 1'b0) $display("FAIL %s_credit_once got %b exp 0", tag, link.in_credit); else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, flit_t'(i), 1'b0);
      n_checks++; if (link.in_credit !== 1'b0) $display("FAIL fill_credit_%0d got %b exp 0", i, link.in_credit); else n_pass++;
    end
    n_checks++; if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (link.out_data !== flit_t'(i)) $display("FAIL drain_data_%0d got %h exp %h", i, link.out_data, flit_t'(i)); else n_pass++;
      cycle(1'b0, '0, 1'b1);
      n_checks++; if (link.in_credit !== 1'b1) $display("FAIL drain_credit_%0d got %b exp 1", i, link.in_credit); else n_pass++;
    end
    n_checks++; if (count !== 3'd0) $display("FAIL drain_count got %0d exp 0", count); else n_pass++;
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    int credits = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, flit_t'(16'h0010 + i), 1'b0);
      n_checks++; if (count !== 3'd1) $display("FAIL wrap_count1_%0d got %0d exp 1", i, count); else n_pass++;
      n_checks++; if (link.out_data !== flit_t'(16'h0010 + i)) $display("FAIL wrap_data_%0d got %h exp %h", i, link.out_data, flit_t'(16'h0010 + i)); else n_pass++;
      if (link.in_credit === 1'b1) credits++;
      cycle(1'b0, '0, 1'b1);
      n_checks++; if (count !== 3'd0) $display("FAIL wrap_count0_%0d got %0d exp 0", i, count); else n_pass++;
      if (link.in_credit === 1'b1) credits++;
    end
    n_checks++; if (credits !== 10) $display("FAIL wrap_credits got %0d exp 10", credits); else n_pass++;
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_full_push_pop();
    flit_t exp_order[4] = '{16'h0021, 16'h0022, 16'h0023, 16'hBEEF};
    for (int i = 0; i < 4; i++) cycle(1'b1, flit_t'(16'h0020 + i), 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1);
    n_checks++; if (count !== 3'd4) $display("FAIL fpp_count got %0d exp 4", count); else n_pass++;
    n_checks++; if (err_overflow !== 1'b0) $display("FAIL fpp_err got %b exp 0", err_overflow); else n_pass++;
    n_checks++; if (link.in_credit !== 1'b1) $display("FAIL fpp_credit got %b exp 1", link.in_credit); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (link.out_data !== exp_order[i]) $display("FAIL fpp_order_%0d got %h exp %h", i, link.out_data, exp_order[i]); else n_pass++;
      cycle(1'b0, '0, 1'b1);
    end
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cycle(1'b1, flit_t'(16'h0030 + i), 1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0);
    n_checks++; if (count !== 3'd4) $display("FAIL ovf_count got %0d exp 4", count); else n_pass++;
    n_checks++; if (err_overflow !== 1'b1) $display("FAIL ovf_err got %b exp 1", err_overflow); else n_pass++;
    n_checks++; if (link.in_credit !== 1'b0) $display("FAIL ovf_credit got %b exp 0", link.in_credit); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (link.out_data !== flit_t'(16'h0030 + i)) $display("FAIL ovf_order_%0d got %h exp %h", i, link.out_data, flit_t'(16'h0030 + i)); else n_pass++;
      cycle(1'b0, '0, 1'b1);
    end
    n_checks++; if (link.out_valid !== 1'b0) $display("FAIL ovf_no_dead got valid %b exp 0", link.out_valid); else n_pass++;
    cycle(1'b0, '0, 1'b0);
    n_checks++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", err_overflow); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b1, flit_t'(16'h0040 + i), 1'b0);
    n_checks++; if (count !== 3'd3) $display("FAIL rmid_pre_count got %0d exp 3", count); else n_pass++;
    cycle(1'b0, '0, 1'b1);
    link.out_ready = 1'b0;
    rst = 1'b0;
    model_clear();
    #1;
    n_checks++; if (link.in_credit !== 1'b0) $display("FAIL rmid_credit got %b exp 0", link.in_credit); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL rmid_count got %0d exp 0", count); else n_pass++;
    n_checks++; if (link.out_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", link.out_valid); else n_pass++;
    n_checks++; if (err_overflow !== 1'b0) $display("FAIL rmid_err got %b exp 0", err_overflow); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (link.in_credit !== 1'b0) $display("FAIL rmid_credit_held got %b exp 0", link.in_credit); else n_pass++;
    rst = 1'b1;
    test_single("rmid_single");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, flit_t'($urandom), ($urandom % 2) == 1);
      n_checks++; if (count !== 3'(mq.size())) $display("FAIL rnd_count_%0d got %0d exp %0d", i, count, mq.size()); else n_pass++;
      n_checks++; if (count > 3'(DEPTH)) $display("FAIL rnd_count_bound_%0d got %0d exp <=%0d", i, count, DEPTH); else n_pass++;
      n_checks++; if (link.out_valid !== (mq.size() != 0)) $display("FAIL rnd_valid_%0d got %b exp %b", i, link.out_valid, mq.size() != 0); else n_pass++;
      if (mq.size() != 0) begin
        n_checks++; if (link.out_data !== mq[0]) $display("FAIL rnd_data_%0d got %h exp %h", i, link.out_data, mq[0]); else n_pass++;
      end
      n_checks++; if (link.in_credit !== m_credit) $display("FAIL rnd_credit_%0d got %b exp %b", i, link.in_credit, m_credit); else n_pass++;
      n_checks++; if (err_overflow !== m_err) $display("FAIL rnd_err_%0d got %b exp %b", i, err_overflow, m_err); else n_pass++;
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    n_checks++; if (credits_seen !== pops_model) $display("FAIL rnd_credit_total got %0d exp %0d", credits_seen, pops_model); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_fill_drain();
    test_wrap();
    test_full_push_pop();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_noc_input_buffer
